depacketizer_da_mf: RTL

//  Multi-flit depacketizer for the dest-append translators. Sits between a NoC

---
 rtl/depacketizer_da_mf.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/depacketizer_da_mf.sv
// ============================================================================
// Module  : depacketizer_da_mf
// Brief   : Reassembles up to DEPACKETIZER_WIDTH NoC flits into one wide word
//           and extracts the return dest/VC carried by the head flit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module depacketizer_da_mf #(
    parameter int WIDTH_PKT          = 36,
    parameter int WIDTH_DATA         = 64,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int VC_ADDRESS_WIDTH   = 1,
    parameter int DEPACKETIZER_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_PKT-1:0]        data_in,
    output logic                        ready_out,
    output logic [WIDTH_DATA-1:0]       data_out,
    output logic [ADDRESS_WIDTH-1:0]    return_dest_out,
    output logic [VC_ADDRESS_WIDTH-1:0] return_vc_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic [1:0]                  err_out
);

    localparam int c_FLIT_DATA = WIDTH_PKT - 3 - 2 * (ADDRESS_WIDTH + VC_ADDRESS_WIDTH);
    localparam int c_RV_LSB    = c_FLIT_DATA;
    localparam int c_RD_LSB    = c_FLIT_DATA + VC_ADDRESS_WIDTH;
    localparam int c_HDR_LSB   = c_RD_LSB + ADDRESS_WIDTH;
    localparam int c_CW        = $clog2(DEPACKETIZER_WIDTH + 1);
    localparam logic [c_CW-1:0] c_DW  = c_CW'(DEPACKETIZER_WIDTH);
    localparam logic [c_CW-1:0] c_ONE = c_CW'(1);

    localparam logic [1:0] c_ERR_NONE     = 2'b00;
    localparam logic [1:0] c_ERR_ORPHAN   = 2'b01;
    localparam logic [1:0] c_ERR_TRUNC    = 2'b10;
    localparam logic [1:0] c_ERR_OVERLONG = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ASM  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                      r_state_q, w_state_d;
    logic [c_CW-1:0]             r_count_q, w_count_d;
    logic [WIDTH_DATA-1:0]       r_data_q, w_data_d;
    logic [ADDRESS_WIDTH-1:0]    r_rd_q, w_rd_d;
    logic [VC_ADDRESS_WIDTH-1:0] r_rv_q, w_rv_d;
    logic [1:0]                  r_err_q, w_err_d;

    logic                        w_valid;
    logic                        w_head;
    logic                        w_tail;
    logic                        w_ready;
    logic                        w_accept;
    logic [c_FLIT_DATA-1:0]      w_payload;
    logic [c_CW-1:0]             w_wr_slot;
    logic [c_CW-1:0]             w_count_inc;
    logic [WIDTH_DATA-1:0]       w_spread;
    logic [WIDTH_DATA-1:0]       w_wr_mask;
    logic                        w_unused_hdr;

    assign w_valid      = data_in[WIDTH_PKT-1];
    assign w_head       = data_in[WIDTH_PKT-2];
    assign w_tail       = data_in[WIDTH_PKT-3];
    assign w_payload    = data_in[c_FLIT_DATA-1:0];
    // Forward dest/vc fields are meaningless once the flit reached this port.
    assign w_unused_hdr = ^data_in[WIDTH_PKT-4:c_HDR_LSB];

    // HOLD forwards downstream backpressure so a held packet is never overwritten.
    assign w_ready  = (r_state_q == S_HOLD) ? ready_in : 1'b1;
    assign w_accept = w_valid && w_ready;

    assign w_wr_slot   = w_head ? '0 : r_count_q;
    assign w_count_inc = r_count_q + c_ONE;

    // Every output bit maps to one (slot, payload bit) pair; bits past the
    // assembled width simply have no slot here and are dropped.
    generate
        for (genvar b = 0; b < WIDTH_DATA; b++) begin : g_bit
            localparam int c_SLOT = b / c_FLIT_DATA;
            localparam int c_OFF  = b % c_FLIT_DATA;
            assign w_spread[b]  = w_payload[c_OFF];
            assign w_wr_mask[b] = (w_wr_slot == c_CW'(c_SLOT));
        end
    endgenerate

    always_comb begin
        w_state_d = r_state_q;
        w_count_d = r_count_q;
        w_data_d  = r_data_q;
        w_rd_d    = r_rd_q;
        w_rv_d    = r_rv_q;
        w_err_d   = c_ERR_NONE;

        if (r_state_q == S_HOLD && ready_in) begin
            w_state_d = S_IDLE;
        end

        if (w_accept) begin
            if (w_head) begin
                w_data_d  = w_spread & w_wr_mask;
                w_rd_d    = data_in[c_RD_LSB +: ADDRESS_WIDTH];
                w_rv_d    = data_in[c_RV_LSB +: VC_ADDRESS_WIDTH];
                w_count_d = c_ONE;
                if (w_tail || (DEPACKETIZER_WIDTH == 1)) begin
                    w_state_d = S_HOLD;
                end else begin
                    w_state_d = S_ASM;
                end
                if (r_state_q == S_ASM) begin
                    w_err_d = c_ERR_TRUNC;
                end
            end else if (r_state_q == S_ASM) begin
                w_data_d  = (r_data_q & ~w_wr_mask) | (w_spread & w_wr_mask);
                w_count_d = (r_count_q == c_DW) ? c_DW : w_count_inc;
                if (w_tail) begin
                    w_state_d = S_HOLD;
                end else if (w_count_inc == c_DW) begin
                    w_state_d = S_HOLD;
                    w_err_d   = c_ERR_OVERLONG;
                end
            end else begin
                w_err_d = c_ERR_ORPHAN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_count_q <= '0;
            r_data_q  <= '0;
            r_rd_q    <= '0;
            r_rv_q    <= '0;
            r_err_q   <= c_ERR_NONE;
        end else begin
            r_state_q <= w_state_d;
            r_count_q <= w_count_d;
            r_data_q  <= w_data_d;
            r_rd_q    <= w_rd_d;
            r_rv_q    <= w_rv_d;
            r_err_q   <= w_err_d;
        end
    end

    assign ready_out       = w_ready;
    assign valid_out       = (r_state_q == S_HOLD);
    assign data_out        = r_data_q;
    assign return_dest_out = r_rd_q;
    assign return_vc_out   = r_rv_q;
    assign err_out         = r_err_q;

endmodule

`default_nettype wire
